// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: datapath widths and ALU op encodings.
package id_ex_stage_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_SEQ = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_XOR = 4'd7
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: MEM result beats WB result, which beats the register-file value.
module fwd_mux #(
  parameter int XLEN = id_ex_stage_pkg::XLEN,
  parameter int RA_W = id_ex_stage_pkg::RA_W
) (
  input  logic [RA_W-1:0] src_addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] data
);
  import id_ex_stage_pkg::*;

  // x0 is hardwired to zero, so a pending write to it must never be forwarded
  always_comb begin
    data = reg_data;
    if (src_addr != '0) begin
      if (mem_reg_write && (mem_rd_addr == src_addr)) begin
        data = mem_result;
      end else if (wb_reg_write && (wb_rd_addr == src_addr)) begin
        data = wb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, load-use stall, flush and
// forwarded ALU operands.
module id_ex_stage #(
  parameter int XLEN = id_ex_stage_pkg::XLEN,
  parameter int RA_W = id_ex_stage_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic [3:0]      id_alu_control,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic            mem_reg_write,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] wb_result,
  output logic            stg_en,
  output logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] in2,
  output logic [3:0]      alu_control,
  input  logic            ex_ready,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  input  logic            flush
);
  import id_ex_stage_pkg::*;

  logic            ex_valid;
  logic [RA_W-1:0] ex_rs1_addr;
  logic [RA_W-1:0] ex_rs2_addr;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic            ex_use_imm;
  logic            ex_reg_write_q;
  logic            ex_mem_read_q;
  logic            load_use;
  logic            capture;
  logic [XLEN-1:0] rs2_fwd;

  // A load in EX cannot forward its data yet, so a dependent instruction must wait a cycle
  assign load_use = ex_valid && ex_mem_read_q && (ex_rd_addr != '0) &&
                    ((ex_rd_addr == id_rs1_addr) ||
                     (!id_use_imm && (ex_rd_addr == id_rs2_addr)));

  assign id_ready = (!ex_valid || ex_ready) && !load_use;
  assign capture  = id_valid && id_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_rs1_addr    <= '0;
      ex_rs2_addr    <= '0;
      ex_rd_addr     <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_use_imm     <= 1'b0;
      alu_control    <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (capture) begin
      ex_valid       <= 1'b1;
      ex_rs1_addr    <= id_rs1_addr;
      ex_rs2_addr    <= id_rs2_addr;
      ex_rd_addr     <= id_rd_addr;
      ex_rs1_data    <= id_rs1_data;
      ex_rs2_data    <= id_rs2_data;
      ex_imm         <= id_imm;
      ex_use_imm     <= id_use_imm;
      alu_control    <= id_alu_control;
      ex_reg_write_q <= id_reg_write;
      ex_mem_read_q  <= id_mem_read;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign stg_en       = ex_valid;
  assign ex_reg_write = ex_reg_write_q && ex_valid;
  assign ex_mem_read  = ex_mem_read_q && ex_valid;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .src_addr      (ex_rs1_addr),
    .reg_data      (ex_rs1_data),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .data          (in1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .src_addr      (ex_rs2_addr),
    .reg_data      (ex_rs2_data),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .data          (rs2_fwd)
  );

  assign in2 = ex_use_imm ? ex_imm : rs2_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by random traffic checked
// against a transaction-level model of the EX slot.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic            id_ready;
  logic [RA_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic            id_use_imm;
  logic [3:0]      id_alu_control;
  logic            id_reg_write, id_mem_read;
  logic [RA_W-1:0] mem_rd_addr, wb_rd_addr;
  logic            mem_reg_write, wb_reg_write;
  logic [XLEN-1:0] mem_result, wb_result;
  logic            stg_en;
  logic [XLEN-1:0] in1, in2;
  logic [3:0]      alu_control;
  logic            ex_ready;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_reg_write, ex_mem_read;
  logic            flush;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_control(id_alu_control),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_result(mem_result), .wb_result(wb_result),
    .stg_en(stg_en), .in1(in1), .in2(in2), .alu_control(alu_control),
    .ex_ready(ex_ready), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .flush(flush)
  );

  // The instruction the model believes is sitting in EX
  typedef struct {
    logic            valid;
    logic [RA_W-1:0] rs1a, rs2a, rd;
    logic [XLEN-1:0] rs1d, rs2d, imm;
    logic            use_imm;
    logic [3:0]      alu;
    logic            rw, mr;
  } ex_slot_t;

  ex_slot_t m;
  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic modelReady();
    logic hazard;
    hazard = m.valid && m.mr && (m.rd != 0) &&
             ((m.rd == id_rs1_addr) || (!id_use_imm && (m.rd == id_rs2_addr)));
    return (!m.valid || ex_ready) && !hazard;
  endfunction

  function automatic logic [XLEN-1:0] modelFwd(input logic [RA_W-1:0] a,
                                               input logic [XLEN-1:0] d);
    if (a == 0) return d;
    if (mem_reg_write && mem_rd_addr == a) return mem_result;
    if (wb_reg_write && wb_rd_addr == a) return wb_result;
    return d;
  endfunction

  task automatic modelReset();
    m = '{valid: 1'b0, rs1a: '0, rs2a: '0, rd: '0, rs1d: '0, rs2d: '0, imm: '0,
          use_imm: 1'b0, alu: '0, rw: 1'b0, mr: 1'b0};
  endtask

  task automatic checkAll();
    checkOutput("id_ready", XLEN'(id_ready), XLEN'(modelReady()));
    checkOutput("stg_en", XLEN'(stg_en), XLEN'(m.valid));
    checkOutput("ex_reg_write", XLEN'(ex_reg_write), XLEN'(m.valid & m.rw));
    checkOutput("ex_mem_read", XLEN'(ex_mem_read), XLEN'(m.valid & m.mr));
    if (m.valid) begin
      checkOutput("in1", in1, modelFwd(m.rs1a, m.rs1d));
      checkOutput("in2", in2, m.use_imm ? m.imm : modelFwd(m.rs2a, m.rs2d));
      checkOutput("alu_control", XLEN'(alu_control), XLEN'(m.alu));
      checkOutput("ex_rd_addr", XLEN'(ex_rd_addr), XLEN'(m.rd));
    end
  endtask

  // Advance one clock; the model applies the slot rules to the inputs held across the edge
  task automatic tick();
    logic acc;
    acc = id_valid && modelReady() && !flush;
    @(posedge clk);
    if (flush) m.valid = 1'b0;
    else if (acc)
      m = '{valid: 1'b1, rs1a: id_rs1_addr, rs2a: id_rs2_addr, rd: id_rd_addr,
            rs1d: id_rs1_data, rs2d: id_rs2_data, imm: id_imm, use_imm: id_use_imm,
            alu: id_alu_control, rw: id_reg_write, mr: id_mem_read};
    else if (ex_ready) m.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clearInputs();
    id_valid = 0; id_rs1_addr = 1; id_rs2_addr = 2; id_rd_addr = 9;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0;
    id_alu_control = 0; id_reg_write = 0; id_mem_read = 0;
    mem_rd_addr = 0; wb_rd_addr = 0; mem_reg_write = 0; wb_reg_write = 0;
    mem_result = 0; wb_result = 0; ex_ready = 1; flush = 0;
  endtask

  task automatic applyStimulus();
    id_valid       = ($urandom_range(0, 3) != 0);
    id_rs1_addr    = RA_W'($urandom_range(0, 7));
    id_rs2_addr    = RA_W'($urandom_range(0, 7));
    id_rd_addr     = RA_W'($urandom_range(0, 7));
    id_rs1_data    = $urandom;
    id_rs2_data    = $urandom;
    id_imm         = $urandom;
    id_use_imm     = $urandom_range(0, 1) != 0;
    id_alu_control = 4'($urandom_range(0, 15));
    id_reg_write   = $urandom_range(0, 1) != 0;
    id_mem_read    = $urandom_range(0, 2) == 0;
    mem_rd_addr    = RA_W'($urandom_range(0, 7));
    wb_rd_addr     = RA_W'($urandom_range(0, 7));
    mem_reg_write  = $urandom_range(0, 1) != 0;
    wb_reg_write   = $urandom_range(0, 1) != 0;
    mem_result     = $urandom;
    wb_result      = $urandom;
    ex_ready       = $urandom_range(0, 3) != 0;
    flush          = $urandom_range(0, 15) == 0;
  endtask

  initial begin
    rst = 1'b1;
    clearInputs();
    modelReset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_stg_en", XLEN'(stg_en), '0);
    checkOutput("rst_in1", in1, '0);
    checkOutput("rst_alu", XLEN'(alu_control), '0);
    checkOutput("rst_id_ready", XLEN'(id_ready), XLEN'(1));
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] capture");
    id_valid = 1; id_rs1_data = 5; id_rs2_data = 7; id_alu_control = 2; id_reg_write = 1;
    #1 checkAll();
    tick();
    id_valid = 0;
    #1 checkAll();
    checkOutput("cap_stg_en", XLEN'(stg_en), XLEN'(1));
    checkOutput("cap_in1", in1, 5);
    checkOutput("cap_in2", in2, 7);
    checkOutput("cap_alu", XLEN'(alu_control), 2);

    $display("[TB] mem/wb priority");
    clearInputs();
    id_valid = 1; id_rs1_addr = 3; id_rs1_data = 32'h11;
    tick();
    id_valid = 0; ex_ready = 0;
    mem_rd_addr = 3; mem_reg_write = 1; mem_result = 32'hAA;
    wb_rd_addr = 3; wb_reg_write = 1; wb_result = 32'hBB;
    #1 checkOutput("fwd_mem", in1, 32'hAA);
    checkAll();
    mem_reg_write = 0;
    #1 checkOutput("fwd_wb", in1, 32'hBB);
    checkAll();
    clearInputs();
    tick();

    $display("[TB] load-use");
    id_valid = 1; id_rd_addr = 4; id_mem_read = 1; id_reg_write = 1;
    tick();
    id_mem_read = 0; id_rs1_addr = 4; id_rd_addr = 5; id_rs1_data = 32'h44;
    #1 checkOutput("lu_ready", XLEN'(id_ready), '0);
    checkAll();
    tick();
    #1 checkOutput("lu_bubble", XLEN'(stg_en), '0);
    checkOutput("lu_ready_after", XLEN'(id_ready), XLEN'(1));
    tick();
    id_valid = 0;
    #1 checkOutput("lu_accept", XLEN'(stg_en), XLEN'(1));
    checkOutput("lu_in1", in1, 32'h44);
    checkAll();

    $display("[TB] stall");
    clearInputs();
    id_valid = 1; id_rs1_data = 32'h123; id_rs2_data = 32'h456; id_alu_control = 6;
    tick();
    ex_ready = 0; id_rs1_data = 32'hDEAD; id_rs2_data = 32'hBEEF; id_alu_control = 3;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("stall_in1", in1, 32'h123);
      checkOutput("stall_in2", in2, 32'h456);
      checkOutput("stall_alu", XLEN'(alu_control), 6);
      checkOutput("stall_ready", XLEN'(id_ready), '0);
      checkAll();
      tick();
    end
    clearInputs();
    tick();

    $display("[TB] flush");
    id_valid = 1; id_reg_write = 1; flush = 1;
    #1 checkAll();
    tick();
    flush = 0; id_valid = 0;
    #1 checkOutput("flush_stg_en", XLEN'(stg_en), '0);
    checkOutput("flush_reg_write", XLEN'(ex_reg_write), '0);

    $display("[TB] reset mid-stall");
    id_valid = 1; id_reg_write = 1; id_rs1_addr = 2; id_rs1_data = 32'h77; id_alu_control = 5;
    tick();
    id_valid = 0; ex_ready = 0;
    #1 checkOutput("pre_rst_stg_en", XLEN'(stg_en), XLEN'(1));
    #2 rst = 1'b1;
    #1 checkOutput("async_rst_stg_en", XLEN'(stg_en), '0);
    checkOutput("async_rst_reg_write", XLEN'(ex_reg_write), '0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    #1 checkOutput("post_rst_alu", XLEN'(alu_control), '0);
    checkOutput("post_rst_rd", XLEN'(ex_rd_addr), '0);
    checkAll();
    id_valid = 1; id_rs1_addr = 0; id_rs1_data = 32'h55;
    tick();
    id_valid = 0; ex_ready = 0;
    mem_rd_addr = 0; mem_reg_write = 1; mem_result = 32'h99;
    wb_rd_addr = 0; wb_reg_write = 1; wb_result = 32'h98;
    #1 checkOutput("post_rst_capture", XLEN'(stg_en), XLEN'(1));
    checkOutput("x0_no_fwd", in1, 32'h55);
    checkAll();
    clearInputs();
    tick();

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus();
      #1 checkAll();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
